// File: rtl/uart_frame_sequencer_if.sv
// Bundle of UART, sample-memory, FFT and result-memory handshake signals
// between the frame sequencer (master) and its surroundings (slave).
interface uart_frame_sequencer_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [7:0]        rx_byte;
  logic              rx_done;
  logic [7:0]        tx_byte;
  logic              tx_enable;
  logic              tx_busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;
  logic              fft_start;
  logic              fft_done;
  logic [ADDR_W-1:0] res_raddr;
  logic [15:0]       res_rdata;
  logic              busy;
  logic              err;
  logic              frame_led;

  modport master (
    input  rx_byte, rx_done, tx_busy, fft_done, res_rdata,
    output tx_byte, tx_enable, mem_we, mem_waddr, mem_wdata, fft_start, res_raddr,
           busy, err, frame_led
  );

  modport slave (
    output rx_byte, rx_done, tx_busy, fft_done, res_rdata,
    input  tx_byte, tx_enable, mem_we, mem_waddr, mem_wdata, fft_start, res_raddr,
           busy, err, frame_led
  );
endinterface

// File: rtl/uart_frame_sequencer.sv
// Per-frame controller: sync hunt, sample load, FFT start/wait with timeout,
// then header plus 16-bit results streamed out through the byte transmitter.
module uart_frame_sequencer #(
  parameter int unsigned N_POINTS  = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 65535
) (
  input logic                    hwclk,
  input logic                    rst_n,
  uart_frame_sequencer_if.master bus
);

  localparam int unsigned BidxW = ADDR_W + 1;
  localparam int unsigned TmoW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BidxW-1:0]  LastBidx = BidxW'(2 * N_POINTS - 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_POINTS - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StStart, StWait, StTxHdr, StTxLo, StTxHi
  } state_e;

  // Per-byte transmit sub-phase; PhRead gives the result memory its read cycle.
  typedef enum logic [1:0] {PhRead, PhSend, PhWaitHi, PhWaitLo} phase_e;

  state_e            state_q;
  phase_e            phase_q;
  logic              rx_q;
  logic [BidxW-1:0]  bidx_q;
  logic [7:0]        low_q;
  logic [TmoW-1:0]   tmo_q;
  logic [7:0]        tx_byte_q;
  logic              tx_enable_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_waddr_q;
  logic [15:0]       mem_wdata_q;
  logic              fft_start_q;
  logic [ADDR_W-1:0] res_raddr_q;
  logic              busy_q;
  logic              err_q;
  logic              frame_led_q;

  logic       new_byte;
  logic       overrun;
  logic [7:0] tx_src;

  assign new_byte = bus.rx_done & ~rx_q;
  assign overrun  = new_byte & (state_q != StIdle) & (state_q != StLoad);

  always_comb begin
    tx_src = 8'h00;
    unique case (state_q)
      StTxHdr: tx_src = SYNC_BYTE;
      StTxLo:  tx_src = bus.res_rdata[7:0];
      StTxHi:  tx_src = bus.res_rdata[15:8];
      default: tx_src = 8'h00;
    endcase
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      phase_q     <= PhSend;
      rx_q        <= 1'b1;
      bidx_q      <= '0;
      low_q       <= '0;
      tmo_q       <= '0;
      tx_byte_q   <= '0;
      tx_enable_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      fft_start_q <= 1'b0;
      res_raddr_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_led_q <= 1'b0;
    end else begin
      rx_q        <= bus.rx_done;
      tx_enable_q <= 1'b0;
      mem_we_q    <= 1'b0;
      fft_start_q <= 1'b0;
      if (overrun) err_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (new_byte && bus.rx_byte == SYNC_BYTE) begin
            err_q   <= 1'b0;
            bidx_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (new_byte) begin
            bidx_q <= bidx_q + BidxW'(1);
            if (!bidx_q[0]) begin
              low_q <= bus.rx_byte;
            end else begin
              mem_we_q    <= 1'b1;
              mem_waddr_q <= bidx_q[BidxW-1:1];
              mem_wdata_q <= {bus.rx_byte, low_q};
              if (bidx_q == LastBidx) state_q <= StStart;
            end
          end
        end
        StStart: begin
          fft_start_q <= 1'b1;
          tmo_q       <= TmoW'(TIMEOUT - 1);
          state_q     <= StWait;
        end
        StWait: begin
          // The start-pulse cycle counts towards the timeout but done is not sampled in it.
          if (!fft_start_q && bus.fft_done) begin
            res_raddr_q <= '0;
            phase_q     <= PhSend;
            state_q     <= StTxHdr;
          end else if (tmo_q == '0) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            tmo_q <= tmo_q - TmoW'(1);
          end
        end
        StTxHdr, StTxLo, StTxHi: begin
          unique case (phase_q)
            PhRead: phase_q <= PhSend;
            PhSend: begin
              if (!bus.tx_busy) begin
                tx_byte_q   <= tx_src;
                tx_enable_q <= 1'b1;
                phase_q     <= PhWaitHi;
              end
            end
            PhWaitHi: if (bus.tx_busy) phase_q <= PhWaitLo;
            PhWaitLo: begin
              if (!bus.tx_busy) begin
                if (state_q == StTxHdr) begin
                  phase_q <= PhRead;
                  state_q <= StTxLo;
                end else if (state_q == StTxLo) begin
                  phase_q <= PhSend;
                  state_q <= StTxHi;
                end else if (res_raddr_q == LastAddr) begin
                  frame_led_q <= ~frame_led_q;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
                end else begin
                  res_raddr_q <= res_raddr_q + ADDR_W'(1);
                  phase_q     <= PhRead;
                  state_q     <= StTxLo;
                end
              end
            end
            default: phase_q <= PhSend;
          endcase
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_enable = tx_enable_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.fft_start = fft_start_q;
  assign bus.res_raddr = res_raddr_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.frame_led = frame_led_q;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Bench for uart_frame_sequencer: byte-level UART, FFT, memory and transmitter
// models with expectations computed from frame contents.
module tb_uart_frame_sequencer;
  localparam int unsigned NP   = 4;
  localparam int unsigned AW   = 2;
  localparam int unsigned TMO  = 50;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam int unsigned OW   = 30 + 2 * AW;

  logic hwclk = 1'b0;
  logic rst_n = 1'b0;

  uart_frame_sequencer_if #(.ADDR_W(AW)) bus ();

  uart_frame_sequencer #(
    .N_POINTS (NP),
    .ADDR_W   (AW),
    .SYNC_BYTE(SYNC),
    .TIMEOUT  (TMO)
  ) dut (
    .hwclk(hwclk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 hwclk = ~hwclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [15:0]   wr_data_q[$];
  int            wr_cyc_q[$];
  int            start_cyc_q[$];
  logic [7:0]    tx_q[$];
  int            edge_q[$];
  int            busy_viol    = 0;
  int            err_rise_cyc = -1;
  logic          err_prev     = 1'b0;
  logic [15:0]   res_mem [NP];
  logic [7:0]    frame_b [2*NP];
  bit            fft_en   = 1'b1;
  int            done_cnt = 0;
  int            busy_cnt = 0;
  int            busy_len = 100;
  logic          exp_led  = 1'b0;

  always @(posedge hwclk) bus.res_rdata <= res_mem[bus.res_raddr];

  // Observers plus transmitter and FFT behaviour, all mid-cycle.
  always @(negedge hwclk) begin
    cyc++;
    if (bus.mem_we) begin
      wr_addr_q.push_back(bus.mem_waddr);
      wr_data_q.push_back(bus.mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.fft_start) start_cyc_q.push_back(cyc);
    if (bus.tx_enable) begin
      if (bus.tx_busy || busy_cnt != 0) busy_viol++;
      tx_q.push_back(bus.tx_byte);
    end
    if (bus.err && !err_prev) err_rise_cyc = cyc;
    err_prev = bus.err;
    if (bus.tx_enable) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    bus.tx_busy  = (busy_cnt != 0);
    bus.fft_done = 1'b0;
    if (bus.fft_start && fft_en) begin
      done_cnt = 10;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) bus.fft_done = 1'b1;
    end
  end

  function automatic logic [OW-1:0] outs();
    return {bus.tx_byte, bus.tx_enable, bus.mem_we, bus.mem_waddr, bus.mem_wdata,
            bus.fft_start, bus.res_raddr, bus.busy, bus.err, bus.frame_led};
  endfunction

  task automatic clear_sb();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    start_cyc_q.delete(); tx_q.delete(); edge_q.delete();
    busy_viol = 0; err_rise_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge hwclk); #1;
    bus.rx_byte = b;
    bus.rx_done = 1'b1;
    edge_q.push_back(cyc);
    repeat ($urandom_range(1, 3)) @(negedge hwclk);
    #1 bus.rx_done = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge hwclk);
  endtask

  task automatic send_frame();
    send_byte(SYNC);
    for (int i = 0; i < 2 * NP; i++) send_byte(frame_b[i]);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      @(negedge hwclk); #1;
      if (!bus.busy) break;
    end
    ok = !bus.busy;
  endtask

  task automatic test_reset();
    bus.rx_done = 1'b1;
    bus.rx_byte = SYNC;
    rst_n = 1'b0;
    repeat (3) @(negedge hwclk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge hwclk); #1;
      n_cmp++;
      if (outs() !== '0) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: outputs=%h want 0", i, outs());
      end
    end
    #1 bus.rx_done = 1'b0;
    repeat (3) @(negedge hwclk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_rx_low_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_directed_frame();
    bit ok;
    logic [7:0] exp_tx [2*NP+1];
    frame_b = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
    res_mem = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    exp_tx  = '{8'hA5, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
    busy_len = 100; fft_en = 1'b1;
    clear_sb();
    send_byte(8'h11);
    send_byte(8'h22);
    send_frame();
    repeat (3) @(negedge hwclk);
    n_cmp++;
    if (wr_addr_q.size() != NP) begin
      n_bad++; $display("FAIL dir_wr_count: got %0d want %0d", wr_addr_q.size(), NP);
    end else begin
      for (int i = 0; i < NP; i++) begin
        n_cmp++;
        if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== 16'(i + 1)) begin
          n_bad++;
          $display("FAIL dir_wr%0d: got a=%0d d=%h want a=%0d d=%h", i, wr_addr_q[i],
                   wr_data_q[i], i, 16'(i + 1));
        end
        n_cmp++;
        if (wr_cyc_q[i] != edge_q[3 + 2 * i + 1] + 1) begin
          n_bad++;
          $display("FAIL dir_wr_lat%0d: got %0d want %0d", i, wr_cyc_q[i] - edge_q[4 + 2 * i], 1);
        end
      end
      n_cmp++;
      if (start_cyc_q.size() != 1 || start_cyc_q[0] != wr_cyc_q[NP-1] + 1) begin
        n_bad++;
        $display("FAIL dir_fft_start: got n=%0d want n=1 at last write+1", start_cyc_q.size());
      end
    end
    wait_idle(3000, ok);
    exp_led = ~exp_led;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL dir_idle_timeout: busy=%b want 0", bus.busy); end
    n_cmp++;
    if (tx_q.size() != 2 * NP + 1) begin
      n_bad++; $display("FAIL dir_tx_count: got %0d want %0d", tx_q.size(), 2 * NP + 1);
    end else begin
      for (int i = 0; i < 2 * NP + 1; i++) begin
        n_cmp++;
        if (tx_q[i] !== exp_tx[i]) begin
          n_bad++; $display("FAIL dir_tx%0d: got %h want %h", i, tx_q[i], exp_tx[i]);
        end
      end
    end
    n_cmp++;
    if (busy_viol != 0) begin n_bad++; $display("FAIL dir_tx_busy: got %0d want 0", busy_viol); end
    n_cmp++;
    if (bus.frame_led !== exp_led) begin
      n_bad++; $display("FAIL dir_led: got %b want %b", bus.frame_led, exp_led);
    end
  endtask

  task automatic test_random_frames();
    bit ok;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 2 * NP; i++) frame_b[i] = 8'($urandom);
      if (f == 0) frame_b[1] = SYNC;
      for (int i = 0; i < NP; i++) res_mem[i] = 16'($urandom);
      busy_len = $urandom_range(2, 30);
      clear_sb();
      send_frame();
      wait_idle(3000, ok);
      exp_led = ~exp_led;
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL rnd%0d_idle_timeout: busy=%b want 0", f, bus.busy); end
      n_cmp++;
      if (wr_addr_q.size() != NP) begin
        n_bad++; $display("FAIL rnd%0d_wr_count: got %0d want %0d", f, wr_addr_q.size(), NP);
      end else begin
        for (int i = 0; i < NP; i++) begin
          n_cmp++;
          if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== {frame_b[2*i+1], frame_b[2*i]}) begin
            n_bad++;
            $display("FAIL rnd%0d_wr%0d: got a=%0d d=%h want a=%0d d=%h", f, i, wr_addr_q[i],
                     wr_data_q[i], i, {frame_b[2*i+1], frame_b[2*i]});
          end
        end
      end
      n_cmp++;
      if (tx_q.size() != 2 * NP + 1) begin
        n_bad++; $display("FAIL rnd%0d_tx_count: got %0d want %0d", f, tx_q.size(), 2 * NP + 1);
      end else begin
        n_cmp++;
        if (tx_q[0] !== SYNC) begin
          n_bad++; $display("FAIL rnd%0d_hdr: got %h want %h", f, tx_q[0], SYNC);
        end
        for (int i = 0; i < NP; i++) begin
          n_cmp++;
          if ({tx_q[2*i+2], tx_q[2*i+1]} !== res_mem[i]) begin
            n_bad++;
            $display("FAIL rnd%0d_res%0d: got %h%h want %h", f, i, tx_q[2*i+2], tx_q[2*i+1],
                     res_mem[i]);
          end
        end
      end
      n_cmp++;
      if (busy_viol != 0 || bus.frame_led !== exp_led) begin
        n_bad++;
        $display("FAIL rnd%0d_busy_led: viol=%0d led=%b want viol=0 led=%b", f, busy_viol,
                 bus.frame_led, exp_led);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    for (int i = 0; i < 2 * NP; i++) frame_b[i] = 8'($urandom);
    fft_en = 1'b0; busy_len = 20;
    clear_sb();
    send_frame();
    for (int i = 0; i < 400 && !bus.err; i++) begin @(negedge hwclk); #1; end
    n_cmp++;
    if (bus.err !== 1'b1 || start_cyc_q.size() != 1) begin
      n_bad++;
      $display("FAIL tmo_err: got err=%b starts=%0d want err=1 starts=1", bus.err,
               start_cyc_q.size());
    end else begin
      n_cmp++;
      if (err_rise_cyc - start_cyc_q[0] != TMO) begin
        n_bad++;
        $display("FAIL tmo_delay: got %0d want %0d", err_rise_cyc - start_cyc_q[0], TMO);
      end
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL tmo_busy: got %b want 0", bus.busy); end
    repeat (30) @(negedge hwclk);
    #1;
    n_cmp++;
    if (tx_q.size() != 0 || bus.frame_led !== exp_led) begin
      n_bad++;
      $display("FAIL tmo_no_tx: got tx=%0d led=%b want tx=0 led=%b", tx_q.size(),
               bus.frame_led, exp_led);
    end
    fft_en = 1'b1;
    send_byte(SYNC);
    n_cmp++;
    if (bus.err !== 1'b0) begin n_bad++; $display("FAIL tmo_err_clear: got %b want 0", bus.err); end
    for (int i = 0; i < 2 * NP; i++) send_byte(frame_b[i]);
    wait_idle(3000, ok);
    exp_led = ~exp_led;
    n_cmp++;
    if (!ok || tx_q.size() != 2 * NP + 1 || bus.frame_led !== exp_led) begin
      n_bad++;
      $display("FAIL tmo_next_frame: got ok=%b tx=%0d led=%b want ok=1 tx=%0d led=%b", ok,
               tx_q.size(), bus.frame_led, 2 * NP + 1, exp_led);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    for (int i = 0; i < 2 * NP; i++) frame_b[i] = 8'($urandom);
    for (int i = 0; i < NP; i++) res_mem[i] = 16'($urandom);
    busy_len = 25; fft_en = 1'b1;
    clear_sb();
    send_frame();
    for (int i = 0; i < 2000 && tx_q.size() < 3; i++) begin @(negedge hwclk); #1; end
    n_cmp++;
    if (bus.err !== 1'b0) begin n_bad++; $display("FAIL ovr_err_pre: got %b want 0", bus.err); end
    send_byte(8'h77);
    n_cmp++;
    if (bus.err !== 1'b1) begin n_bad++; $display("FAIL ovr_err: got %b want 1", bus.err); end
    wait_idle(3000, ok);
    exp_led = ~exp_led;
    n_cmp++;
    if (!ok || tx_q.size() != 2 * NP + 1) begin
      n_bad++;
      $display("FAIL ovr_tx_count: got %0d want %0d", tx_q.size(), 2 * NP + 1);
    end else begin
      for (int i = 0; i < NP; i++) begin
        n_cmp++;
        if ({tx_q[2*i+2], tx_q[2*i+1]} !== res_mem[i] || tx_q[0] !== SYNC) begin
          n_bad++;
          $display("FAIL ovr_res%0d: got %h%h hdr %h want %h hdr %h", i, tx_q[2*i+2],
                   tx_q[2*i+1], tx_q[0], res_mem[i], SYNC);
        end
      end
    end
    n_cmp++;
    if (bus.err !== 1'b1 || bus.frame_led !== exp_led || busy_viol != 0) begin
      n_bad++;
      $display("FAIL ovr_end: got err=%b led=%b viol=%0d want err=1 led=%b viol=0", bus.err,
               bus.frame_led, busy_viol, exp_led);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    clear_sb();
    send_byte(SYNC);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    #1 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge hwclk); #1;
      n_cmp++;
      if (outs() !== '0) begin
        n_bad++; $display("FAIL rst_mid%0d: outputs=%h want 0", i, outs());
      end
    end
    rst_n = 1'b1;
    exp_led = 1'b0;
    repeat (2) @(negedge hwclk);
    for (int i = 0; i < 2 * NP; i++) frame_b[i] = 8'($urandom);
    clear_sb();
    send_frame();
    wait_idle(3000, ok);
    exp_led = ~exp_led;
    n_cmp++;
    if (wr_addr_q.size() != NP) begin
      n_bad++; $display("FAIL rst_wr_count: got %0d want %0d", wr_addr_q.size(), NP);
    end else begin
      for (int i = 0; i < NP; i++) begin
        n_cmp++;
        if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== {frame_b[2*i+1], frame_b[2*i]}) begin
          n_bad++;
          $display("FAIL rst_wr%0d: got a=%0d d=%h want a=%0d d=%h", i, wr_addr_q[i],
                   wr_data_q[i], i, {frame_b[2*i+1], frame_b[2*i]});
        end
      end
    end
    n_cmp++;
    if (!ok || tx_q.size() != 2 * NP + 1 || bus.frame_led !== exp_led) begin
      n_bad++;
      $display("FAIL rst_frame_end: got ok=%b tx=%0d led=%b want ok=1 tx=%0d led=%b", ok,
               tx_q.size(), bus.frame_led, 2 * NP + 1, exp_led);
    end
  endtask

  initial begin
    bus.rx_byte = 8'h00;
    bus.rx_done = 1'b1;
    for (int i = 0; i < NP; i++) res_mem[i] = '0;
    test_reset();
    test_directed_frame();
    test_random_frames();
    test_timeout();
    test_overrun();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
